bcd_time_of_day: RTL

Parametrised BCD time-of-day counter, the next generation of the structural 24-hour clock. It generates its own 1 Hz tick from the system clock via a prescaler, keeps time internally in 24-hour BCD, and presents it in 12- or 24-hour format. It validates time and alarm loads and raises alarm-match and day-rollover pulses. It sits between the system clock domain and the display and alarm logic.

---
 rtl/bcd_time_of_day.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bcd_time_of_day.sv
// bcd_time_of_day
// 24-hour BCD time-of-day counter with an internal 1 Hz prescaler, validated time/alarm loads,
// 12/24-hour display mapping, and registered second/day/alarm/load-error pulses.
//
// Parameters:
//   TICK_DIV  system clock cycles per advance (>= 1)
//   DIV_W     prescaler width, 2**DIV_W >= TICK_DIV
// Ports:
//   CLK        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   Set_time   load Time_in this cycle (valid values only)
//   Time_in    BCD HHMMSS, 24-hour form
//   Alarm_set  load Alarm_in this cycle (valid values only)
//   Alarm_in   BCD HHMMSS alarm time
//   Alarm_en   enables Alarm pulses
//   Mode_12h   1 = 12-hour display, 0 = 24-hour display
//   Time_out   displayed BCD HHMMSS
//   PM         internal hour >= 12
//   Sec_tick   one-cycle pulse per advance
//   Day_tick   one-cycle pulse on 23:59:59 -> 00:00:00
//   Alarm      one-cycle pulse when an advance lands on the alarm time
//   Load_err   one-cycle pulse when a time or alarm load is rejected
module bcd_time_of_day #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Set_time,
    input  logic [23:0] Time_in,
    input  logic        Alarm_set,
    input  logic [23:0] Alarm_in,
    input  logic        Alarm_en,
    input  logic        Mode_12h,
    output logic [23:0] Time_out,
    output logic        PM,
    output logic        Sec_tick,
    output logic        Day_tick,
    output logic        Alarm,
    output logic        Load_err
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Time digit registers (24-hour BCD)
    logic [3:0]       r_hr_t, r_hr_u, r_mn_t, r_mn_u, r_sc_t, r_sc_u;
    logic [23:0]      r_alarm;
    logic [DIV_W-1:0] r_div;
    logic             r_sec_tick, r_day_tick, r_alarm_pulse, r_load_err;

    logic        w_adv;
    logic        w_time_ok, w_alarm_ok, w_load;
    logic        w_c_su, w_c_st, w_c_mu, w_c_mt, w_hr_23;
    logic [3:0]  w_n_sc_u, w_n_sc_t, w_n_mn_u, w_n_mn_t, w_n_hr_u, w_n_hr_t;
    logic [23:0] w_next_time;
    logic        w_day, w_alarm_hit;
    logic [3:0]  w_disp_ht, w_disp_hu;

    function automatic logic bcd_ok(input logic [23:0] t);
        logic hr_ok;
        hr_ok = (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
                ((t[23:20] != 4'd2) || (t[19:16] <= 4'd3));
        return hr_ok && (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    assign w_adv      = (r_div == DIV_LAST);
    assign w_time_ok  = bcd_ok(Time_in);
    assign w_alarm_ok = bcd_ok(Alarm_in);
    assign w_load     = Set_time && w_time_ok;

    // Ripple carry chain across the six digits
    assign w_c_su  = (r_sc_u == 4'd9);
    assign w_c_st  = w_c_su && (r_sc_t == 4'd5);
    assign w_c_mu  = w_c_st && (r_mn_u == 4'd9);
    assign w_c_mt  = w_c_mu && (r_mn_t == 4'd5);
    assign w_hr_23 = (r_hr_t == 4'd2) && (r_hr_u == 4'd3);

    assign w_n_sc_u = w_c_su ? 4'd0 : r_sc_u + 4'd1;
    assign w_n_sc_t = !w_c_su ? r_sc_t : (w_c_st ? 4'd0 : r_sc_t + 4'd1);
    assign w_n_mn_u = !w_c_st ? r_mn_u : (w_c_mu ? 4'd0 : r_mn_u + 4'd1);
    assign w_n_mn_t = !w_c_mu ? r_mn_t : (w_c_mt ? 4'd0 : r_mn_t + 4'd1);

    always_comb begin
        w_n_hr_t = r_hr_t;
        w_n_hr_u = r_hr_u;
        if (w_c_mt) begin
            if (w_hr_23) begin
                w_n_hr_t = 4'd0;
                w_n_hr_u = 4'd0;
            end else if (r_hr_u == 4'd9) begin
                w_n_hr_t = r_hr_t + 4'd1;
                w_n_hr_u = 4'd0;
            end else begin
                w_n_hr_u = r_hr_u + 4'd1;
            end
        end
    end

    assign w_next_time = {w_n_hr_t, w_n_hr_u, w_n_mn_t, w_n_mn_u, w_n_sc_t, w_n_sc_u};
    assign w_day       = w_c_mt && w_hr_23;
    // Compared against the alarm value held before any same-cycle alarm load
    assign w_alarm_hit = Alarm_en && (w_next_time == r_alarm);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hr_t        <= 4'd0;
            r_hr_u        <= 4'd0;
            r_mn_t        <= 4'd0;
            r_mn_u        <= 4'd0;
            r_sc_t        <= 4'd0;
            r_sc_u        <= 4'd0;
            r_alarm       <= 24'd0;
            r_div         <= '0;
            r_sec_tick    <= 1'b0;
            r_day_tick    <= 1'b0;
            r_alarm_pulse <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_sec_tick    <= 1'b0;
            r_day_tick    <= 1'b0;
            r_alarm_pulse <= 1'b0;
            r_load_err    <= (Set_time && !w_time_ok) || (Alarm_set && !w_alarm_ok);

            if (w_load) begin
                // A valid load wins over a coincident advance, which is dropped
                {r_hr_t, r_hr_u, r_mn_t, r_mn_u, r_sc_t, r_sc_u} <= Time_in;
                r_div <= '0;
            end else begin
                r_div <= w_adv ? '0 : r_div + DIV_W'(1);
                if (w_adv) begin
                    {r_hr_t, r_hr_u, r_mn_t, r_mn_u, r_sc_t, r_sc_u} <= w_next_time;
                    r_sec_tick    <= 1'b1;
                    r_day_tick    <= w_day;
                    r_alarm_pulse <= w_alarm_hit;
                end
            end

            if (Alarm_set && w_alarm_ok) begin
                r_alarm <= Alarm_in;
            end
        end
    end

    // 12-hour mapping: 00 -> 12, 13..19 -> 01..07, 20/21 -> 08/09, 22/23 -> 10/11
    always_comb begin
        w_disp_ht = r_hr_t;
        w_disp_hu = r_hr_u;
        if (Mode_12h) begin
            if (r_hr_t == 4'd0 && r_hr_u == 4'd0) begin
                w_disp_ht = 4'd1;
                w_disp_hu = 4'd2;
            end else if (r_hr_t == 4'd1 && r_hr_u >= 4'd3) begin
                w_disp_ht = 4'd0;
                w_disp_hu = r_hr_u - 4'd2;
            end else if (r_hr_t == 4'd2 && r_hr_u <= 4'd1) begin
                w_disp_ht = 4'd0;
                w_disp_hu = r_hr_u + 4'd8;
            end else if (r_hr_t == 4'd2) begin
                w_disp_ht = 4'd1;
                w_disp_hu = r_hr_u - 4'd2;
            end
        end
    end

    assign Time_out = {w_disp_ht, w_disp_hu, r_mn_t, r_mn_u, r_sc_t, r_sc_u};
    assign PM       = (r_hr_t == 4'd2) || (r_hr_t == 4'd1 && r_hr_u >= 4'd2);
    assign Sec_tick = r_sec_tick;
    assign Day_tick = r_day_tick;
    assign Alarm    = r_alarm_pulse;
    assign Load_err = r_load_err;

endmodule
